// File: rtl/teller_pkg.sv
// Shared constants and teller state encoding for the bank-queue dispatcher.
package teller_pkg;
    localparam int         NUM_TELLERS = 3;
    localparam int         QMAX        = 7;
    localparam logic [2:0] QMAX_V      = 3'(QMAX);

    typedef enum logic [1:0] {
        CLOSED   = 2'b00,
        IDLE     = 2'b01,
        SERVING  = 2'b10,
        DRAINING = 2'b11
    } tstate_e;
endpackage

// File: rtl/teller_dispatcher_rr_arbiter3.sv
// Combinational 3-way round-robin arbiter; search begins one past the last grant.
module rr_arbiter3
    import teller_pkg::*;
(
    input  logic [NUM_TELLERS-1:0] req_i,
    input  logic [1:0]             ptr_i,
    output logic [NUM_TELLERS-1:0] gnt_o,
    output logic [1:0]             ptr_next_o
);

    logic [1:0] o0, o1, o2;

    // Search order starting at ptr+1 mod 3; a pointer value of 3 behaves like 2.
    always_comb begin
        o0 = 2'd0;
        o1 = 2'd1;
        o2 = 2'd2;
        case (ptr_i)
            2'd0: begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
            2'd1: begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
            default: ;
        endcase
    end

    always_comb begin
        gnt_o      = '0;
        ptr_next_o = ptr_i;
        if (req_i[o0]) begin
            gnt_o[o0]  = 1'b1;
            ptr_next_o = o0;
        end else if (req_i[o1]) begin
            gnt_o[o1]  = 1'b1;
            ptr_next_o = o1;
        end else if (req_i[o2]) begin
            gnt_o[o2]  = 1'b1;
            ptr_next_o = o2;
        end
    end

endmodule

// File: rtl/teller_dispatcher.sv
// Bank-queue dispatcher: waiting-customer counter, per-teller service FSMs and
// round-robin dispatch of the queue head to a free, open teller.
module teller_dispatcher
    import teller_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arrive,
    input  logic [2:0] teller_open,
    input  logic [2:0] teller_done,
    output logic [2:0] pcount,
    output logic       empty,
    output logic       full,
    output logic [2:0] busy,
    output logic [2:0] dispatch,
    output logic [1:0] tcount,
    output logic       drop
);

    logic [2:0] pcount_q, pcount_d;
    logic [2:0] dispatch_q;
    logic       drop_q, drop_d;
    logic [1:0] tcount_q, tcount_d;
    logic [1:0] ptr_q, ptr_d;

    logic [2:0] eligible, req, gnt;
    logic [1:0] ptr_next;
    logic       grant_any, acc;

    // No grant from an empty queue, so an arrival can never bypass the counter.
    assign req       = (pcount_q != 3'd0) ? eligible : 3'b000;
    assign grant_any = |gnt;

    rr_arbiter3 u_arb (
        .req_i      (req),
        .ptr_i      (ptr_q),
        .gnt_o      (gnt),
        .ptr_next_o (ptr_next)
    );

    for (genvar i = 0; i < NUM_TELLERS; i++) begin : g_teller
        tstate_e state_q, state_d;

        always_ff @(posedge clk) begin
            if (!rst_n) state_q <= CLOSED;
            else        state_q <= state_d;
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                CLOSED:   if (teller_open[i]) state_d = IDLE;
                IDLE: begin
                    if (gnt[i])               state_d = SERVING;
                    else if (!teller_open[i]) state_d = CLOSED;
                end
                SERVING: begin
                    if (teller_done[i])       state_d = teller_open[i] ? IDLE : CLOSED;
                    else if (!teller_open[i]) state_d = DRAINING;
                end
                DRAINING: begin
                    if (teller_done[i])       state_d = CLOSED;
                    else if (teller_open[i])  state_d = SERVING;
                end
                default:                      state_d = CLOSED;
            endcase
        end

        assign eligible[i] = (state_q == IDLE) && teller_open[i];
        assign busy[i]     = (state_q == SERVING) || (state_q == DRAINING);
    end

    // A full queue still accepts an arrival when a customer leaves in the same cycle.
    always_comb begin
        acc      = arrive && ((pcount_q != QMAX_V) || grant_any);
        drop_d   = arrive && !acc;
        pcount_d = pcount_q + {2'b00, acc} - {2'b00, grant_any};
        tcount_d = {1'b0, teller_open[0]} + {1'b0, teller_open[1]} + {1'b0, teller_open[2]};
        ptr_d    = grant_any ? ptr_next : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcount_q   <= 3'd0;
            dispatch_q <= 3'b000;
            drop_q     <= 1'b0;
            tcount_q   <= 2'd0;
            ptr_q      <= 2'd2;
        end else begin
            pcount_q   <= pcount_d;
            dispatch_q <= gnt;
            drop_q     <= drop_d;
            tcount_q   <= tcount_d;
            ptr_q      <= ptr_d;
        end
    end

    assign pcount   = pcount_q;
    assign empty    = (pcount_q == 3'd0);
    assign full     = (pcount_q == QMAX_V);
    assign dispatch = dispatch_q;
    assign drop     = drop_q;
    assign tcount   = tcount_q;

endmodule

// File: tb/tb_teller_dispatcher.sv
// Directed, table-driven bench for teller_dispatcher with a few hand-written sequences.
module tb_teller_dispatcher;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       arrive;
    logic [2:0] teller_open;
    logic [2:0] teller_done;
    logic [2:0] pcount;
    logic       empty;
    logic       full;
    logic [2:0] busy;
    logic [2:0] dispatch;
    logic [1:0] tcount;
    logic       drop;

    always #5 clk = ~clk;

    teller_dispatcher dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arrive      (arrive),
        .teller_open (teller_open),
        .teller_done (teller_done),
        .pcount      (pcount),
        .empty       (empty),
        .full        (full),
        .busy        (busy),
        .dispatch    (dispatch),
        .tcount      (tcount),
        .drop        (drop)
    );

    typedef struct {
        logic       rst_n;
        logic       arrive;
        logic [2:0] open;
        logic [2:0] done;
        logic [2:0] pc;
        logic [2:0] busy;
        logic [2:0] disp;
        logic [1:0] tc;
        logic       drop;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(int r, int a, int o, int d, int pc, int b, int ds, int tc, int dr);
        vec_t v;
        v.rst_n  = 1'(r);
        v.arrive = 1'(a);
        v.open   = 3'(o);
        v.done   = 3'(d);
        v.pc     = 3'(pc);
        v.busy   = 3'(b);
        v.disp   = 3'(ds);
        v.tc     = 2'(tc);
        v.drop   = 1'(dr);
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [7:0] act, logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic apply(logic r, logic a, logic [2:0] o, logic [2:0] d);
        @(negedge clk);
        rst_n       = r;
        arrive      = a;
        teller_open = o;
        teller_done = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        rst_n       = 1'b0;
        arrive      = 1'b0;
        teller_open = 3'b000;
        teller_done = 3'b000;

        //                 rst arr open done | pc busy disp tc drop
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 7, 0,   1, 0, 0, 3, 0));
        tbl.push_back(mk(1, 0, 7, 0,   0, 1, 1, 3, 0));
        tbl.push_back(mk(1, 0, 7, 0,   0, 1, 0, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0,   1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0,   2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 7, 0,   3, 0, 0, 3, 0));
        tbl.push_back(mk(1, 0, 7, 0,   2, 1, 1, 3, 0));
        tbl.push_back(mk(1, 0, 7, 0,   1, 3, 2, 3, 0));
        tbl.push_back(mk(1, 0, 7, 0,   0, 7, 4, 3, 0));
        tbl.push_back(mk(1, 1, 7, 1,   1, 6, 0, 3, 0));
        tbl.push_back(mk(1, 0, 7, 0,   0, 7, 1, 3, 0));
        for (int k = 1; k <= 5; k++)
            tbl.push_back(mk(1, 1, 7, 0, k, 7, 0, 3, 0));
        tbl.push_back(mk(0, 1, 7, 7,   0, 0, 0, 0, 0));
        for (int k = 1; k <= 7; k++)
            tbl.push_back(mk(1, 1, 0, 0, k, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0,   7, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0,   7, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0,   7, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0,   7, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0,   7, 1, 1, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0,   7, 1, 0, 1, 1));
        tbl.push_back(mk(1, 0, 3, 0,   7, 1, 0, 2, 0));
        tbl.push_back(mk(1, 0, 3, 0,   6, 3, 2, 2, 0));
        tbl.push_back(mk(1, 0, 1, 0,   6, 3, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1,   6, 2, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0,   5, 3, 1, 1, 0));
        tbl.push_back(mk(1, 0, 1, 2,   5, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 3, 0,   5, 1, 0, 2, 0));
        tbl.push_back(mk(1, 0, 3, 0,   4, 3, 2, 2, 0));
        tbl.push_back(mk(1, 0, 1, 0,   4, 3, 0, 1, 0));
        tbl.push_back(mk(1, 0, 3, 0,   4, 3, 0, 2, 0));
        tbl.push_back(mk(1, 0, 3, 2,   4, 1, 0, 2, 0));
        tbl.push_back(mk(1, 0, 3, 6,   3, 3, 2, 2, 0));

        foreach (tbl[i]) begin
            apply(tbl[i].rst_n, tbl[i].arrive, tbl[i].open, tbl[i].done);
            chk("pcount",   i, 8'(pcount),   8'(tbl[i].pc));
            chk("empty",    i, 8'(empty),    8'(tbl[i].pc == 3'd0));
            chk("full",     i, 8'(full),     8'(tbl[i].pc == 3'd7));
            chk("busy",     i, 8'(busy),     8'(tbl[i].busy));
            chk("dispatch", i, 8'(dispatch), 8'(tbl[i].disp));
            chk("tcount",   i, 8'(tcount),   8'(tbl[i].tc));
            chk("drop",     i, 8'(drop),     8'(tbl[i].drop));
        end

        // Arrival-to-dispatch latency from a fresh reset, with a bounded wait.
        apply(1'b0, 1'b0, 3'b000, 3'b000);
        chk("rst_pcount", 100, 8'(pcount), 8'd0);
        chk("rst_busy",   100, 8'(busy),   8'd0);
        apply(1'b1, 1'b1, 3'b111, 3'b000);
        chk("arr_pcount", 101, 8'(pcount), 8'd1);
        chk("arr_nodisp", 101, 8'(dispatch), 8'd0);
        lat = -1;
        for (int k = 1; k <= 6 && lat < 0; k++) begin
            apply(1'b1, 1'b0, 3'b111, 3'b000);
            if (dispatch != 3'b000) begin
                lat = k;
                chk("first_grant", 102, 8'(dispatch), 8'b001);
            end
        end
        chk("latency", 103, 8'(lat), 8'd1);
        apply(1'b1, 1'b0, 3'b111, 3'b000);
        chk("disp_pulse", 104, 8'(dispatch), 8'd0);
        chk("lat_busy",   104, 8'(busy),     8'b001);
        chk("lat_pcount", 104, 8'(pcount),   8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
